// File: rtl/i2c_slave_ctrl.sv
`timescale 1ns/1ps
// i2c_slave_ctrl -- I2C target-side controller.
// Samples open-drain SCL/SDA, detects START/STOP, matches a 7-bit address,
// shifts data bytes in (master write) or out (master read), drives ACK, and
// stretches SCL while read data is not yet available.
// Ports:
//   clk, nReset        system clock, asynchronous active-low reset
//   ena                core enable; low forces IDLE and releases both lines
//   slv_addr[6:0]      own address
//   scl_i/scl_o/scl_oen  SCL line in, constant 0 out, active-low enable
//   sda_i/sda_o/sda_oen  SDA line in, constant 0 out, active-low enable
//   rx_data, rx_valid  received byte and its 1-cycle update pulse
//   rx_nack            1 = NACK the byte being received
//   tx_data, tx_valid  next read byte and its load strobe
//   tx_req             1-cycle request for the next read byte
//   addr_match, rw     addressed flag and latched R/W bit
//   busy, sto_det      bus busy level and STOP pulse
module i2c_slave_ctrl (
  input  logic       clk,
  input  logic       nReset,
  input  logic       ena,
  input  logic [6:0] slv_addr,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oen,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_nack,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_req,
  output logic       addr_match,
  output logic       rw,
  output logic       busy,
  output logic       sto_det
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    RX       = 4'd3,
    RX_ACK   = 4'd4,
    TX       = 4'd5,
    TX_ACK   = 4'd6,
    WAIT_TX  = 4'd7,
    TX_SETUP = 4'd8
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       dscl, dsda;
  logic       sscl, ssda, start_det, stop_det, rise, fall;

  state_t     state, next_state;
  logic [7:0] shift, next_shift;
  logic [2:0] bit_cnt, next_bit_cnt;
  logic       byte_done, next_byte_done;  // 8th rise seen, waiting for the ACK-drive fall
  logic       hit, next_hit;              // address compare result, held until the ACK fall
  logic       got_nack, next_got_nack;    // master ACK bit sampled in TX_ACK
  logic [7:0] tx_buf, next_tx_buf;
  logic       tx_full, next_tx_full;
  logic [7:0] next_rx_data;
  logic       next_rx_valid, next_tx_req, next_addr_match, next_rw;
  logic       next_busy, next_sto_det, next_sda_oen, next_scl_oen;
  logic       load, resume;

  assign scl_o = 1'b0;
  assign sda_o = 1'b0;

  assign sscl      = scl_sync[1];
  assign ssda      = sda_sync[1];
  // Requiring SCL high on both samples keeps an SDA change that coincides
  // with an SCL edge from being mistaken for START/STOP.
  assign start_det = sscl & dscl & ~ssda & dsda;
  assign stop_det  = sscl & dscl & ssda & ~dsda;
  assign rise      = sscl & ~dscl;
  assign fall      = ~sscl & dscl;

  // Line synchronizers plus the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      dscl     <= 1'b1;
      dsda     <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      dscl     <= sscl;
      dsda     <= ssda;
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      shift      <= 8'h00;
      bit_cnt    <= 3'd7;
      byte_done  <= 1'b0;
      hit        <= 1'b0;
      got_nack   <= 1'b0;
      tx_buf     <= 8'h00;
      tx_full    <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      addr_match <= 1'b0;
      rw         <= 1'b0;
      busy       <= 1'b0;
      sto_det    <= 1'b0;
      sda_oen    <= 1'b1;
      scl_oen    <= 1'b1;
    end else begin
      state      <= next_state;
      shift      <= next_shift;
      bit_cnt    <= next_bit_cnt;
      byte_done  <= next_byte_done;
      hit        <= next_hit;
      got_nack   <= next_got_nack;
      tx_buf     <= next_tx_buf;
      tx_full    <= next_tx_full;
      rx_data    <= next_rx_data;
      rx_valid   <= next_rx_valid;
      tx_req     <= next_tx_req;
      addr_match <= next_addr_match;
      rw         <= next_rw;
      busy       <= next_busy;
      sto_det    <= next_sto_det;
      sda_oen    <= next_sda_oen;
      scl_oen    <= next_scl_oen;
    end
  end

  // Next-state, datapath and output decode.
  always_comb begin
    next_state      = state;
    next_shift      = shift;
    next_bit_cnt    = bit_cnt;
    next_byte_done  = byte_done;
    next_hit        = hit;
    next_got_nack   = got_nack;
    next_rx_data    = rx_data;
    next_rx_valid   = 1'b0;
    next_tx_req     = 1'b0;
    next_addr_match = addr_match;
    next_rw         = rw;
    next_sto_det    = 1'b0;
    next_sda_oen    = sda_oen;
    next_scl_oen    = scl_oen;
    load            = 1'b0;
    resume          = 1'b0;

    // Bus busy tracks START/STOP regardless of enable.
    if (stop_det) begin
      next_busy = 1'b0;
    end else if (start_det) begin
      next_busy = 1'b1;
    end else begin
      next_busy = busy;
    end

    if (!ena) begin
      next_state      = IDLE;
      next_sda_oen    = 1'b1;
      next_scl_oen    = 1'b1;
      next_addr_match = 1'b0;
      next_byte_done  = 1'b0;
    end else if (stop_det) begin
      next_state      = IDLE;
      next_sto_det    = 1'b1;
      next_addr_match = 1'b0;
      next_sda_oen    = 1'b1;
      next_scl_oen    = 1'b1;
      next_byte_done  = 1'b0;
    end else if (start_det) begin
      next_state      = ADDR;
      next_bit_cnt    = 3'd7;
      next_byte_done  = 1'b0;
      next_addr_match = 1'b0;
      next_sda_oen    = 1'b1;
      next_scl_oen    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          next_sda_oen = 1'b1;
          next_scl_oen = 1'b1;
        end
        ADDR: begin
          if (rise) begin
            next_shift   = {shift[6:0], ssda};
            next_bit_cnt = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              next_byte_done = 1'b1;
              next_rw        = ssda;
              next_hit       = (shift[6:0] == slv_addr);
            end else begin
              next_byte_done = 1'b0;
            end
          end else if (fall && byte_done) begin
            next_byte_done = 1'b0;
            if (hit) begin
              next_sda_oen    = 1'b0;
              next_addr_match = 1'b1;
              next_tx_req     = rw;
              next_state      = ADDR_ACK;
            end else begin
              next_state = IDLE;
            end
          end else begin
            next_state = ADDR;
          end
        end
        ADDR_ACK: begin
          if (fall) begin
            next_sda_oen = 1'b1;
            if (rw) begin
              resume = 1'b1;
            end else begin
              next_state = RX;
            end
          end else begin
            next_state = ADDR_ACK;
          end
        end
        RX: begin
          if (rise) begin
            next_shift   = {shift[6:0], ssda};
            next_bit_cnt = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              next_rx_data   = {shift[6:0], ssda};
              next_rx_valid  = 1'b1;
              next_byte_done = 1'b1;
            end else begin
              next_byte_done = 1'b0;
            end
          end else if (fall && byte_done) begin
            next_byte_done = 1'b0;
            next_sda_oen   = rx_nack;
            next_state     = RX_ACK;
          end else begin
            next_state = RX;
          end
        end
        RX_ACK: begin
          if (fall) begin
            next_sda_oen = 1'b1;
            next_state   = RX;
          end else begin
            next_state = RX_ACK;
          end
        end
        TX: begin
          // shift[7] is on the bus; each fall advances to the next bit.
          if (fall) begin
            if (bit_cnt == 3'd0) begin
              next_sda_oen = 1'b1;
              next_bit_cnt = 3'd7;
              next_state   = TX_ACK;
            end else begin
              next_shift   = {shift[6:0], 1'b0};
              next_sda_oen = shift[6];
              next_bit_cnt = bit_cnt - 3'd1;
            end
          end else begin
            next_state = TX;
          end
        end
        TX_ACK: begin
          if (rise) begin
            next_got_nack = ssda;
            next_tx_req   = ~ssda;
          end else if (fall) begin
            if (got_nack) begin
              next_state = IDLE;
            end else begin
              resume = 1'b1;
            end
          end else begin
            next_state = TX_ACK;
          end
        end
        WAIT_TX: begin
          next_scl_oen = 1'b0;
          if (tx_full) begin
            load         = 1'b1;
            next_shift   = tx_buf;
            next_bit_cnt = 3'd7;
            next_sda_oen = tx_buf[7];
            next_state   = TX_SETUP;
          end else begin
            next_state = WAIT_TX;
          end
        end
        TX_SETUP: begin
          // MSB has been on SDA for a cycle; now let SCL go.
          next_scl_oen = 1'b1;
          next_state   = TX;
        end
        default: begin
          next_state   = IDLE;
          next_sda_oen = 1'b1;
          next_scl_oen = 1'b1;
        end
      endcase

      // Shared read continuation after the address ACK or a master ACK.
      if (resume) begin
        if (tx_full) begin
          load         = 1'b1;
          next_shift   = tx_buf;
          next_bit_cnt = 3'd7;
          next_sda_oen = tx_buf[7];
          next_state   = TX;
        end else begin
          next_scl_oen = 1'b0;
          next_state   = WAIT_TX;
        end
      end else begin
        next_shift = next_shift;
      end
    end

    // A new strobe wins over a same-cycle load so the fresh byte is kept.
    next_tx_buf  = tx_buf;
    next_tx_full = tx_full;
    if (tx_valid) begin
      next_tx_buf  = tx_data;
      next_tx_full = 1'b1;
    end else if (load) begin
      next_tx_full = 1'b0;
    end else begin
      next_tx_full = tx_full;
    end
  end

endmodule

// File: doc/i2c_slave_ctrl.md
# i2c_slave_ctrl

I2C slave-side controller, the target counterpart of the master bit/byte controllers in the i2c core. Samples the open-drain SCL/SDA lines and detects START/STOP. Matches a 7-bit address and shifts bytes in or out, driving ACK and data onto SDA. Stretches SCL when read data is not ready, and exchanges bytes with the host logic through a simple pulse/valid interface.

## Interface
- Parameters: none.
- clk  in  1  system clock; must be ≥10× SCL frequency.
- nReset  in  1  asynchronous, active-low reset.
- ena  in  1  core enable; low forces IDLE and releases both lines.
- slv_addr  in  7  own slave address; sampled at address compare.
- scl_i  in  1  SCL line input.
- scl_o  out  1  constant 0.
- scl_oen  out  1  SCL output enable, active low (0 = pull low / stretch).
- sda_i  in  1  SDA line input.
- sda_o  out  1  constant 0.
- sda_oen  out  1  SDA output enable, active low.
- rx_data  out  8  last received data byte.
- rx_valid  out  1  1-cycle pulse when rx_data updates.
- rx_nack  in  1  1 = NACK the byte currently being received; sampled at the ACK drive point.
- tx_data  in  8  next byte for a master read.
- tx_valid  in  1  1-cycle strobe loading tx_data into the tx buffer.
- tx_req  out  1  1-cycle pulse requesting the next read byte.
- addr_match  out  1  level; high while this slave is addressed.
- rw  out  1  latched R/W bit of the current transaction (1 = master read).
- busy  out  1  bus busy: set by START, cleared by STOP.
- sto_det  out  1  1-cycle pulse on STOP detection.

## Operation
- Two-flop synchronizers give sSCL/sSDA. A further delayed copy gives dSCL/dSDA for edge detection.
  - START: sSDA falls while sSCL is high.
  - STOP: sSDA rises while sSCL is high.
  - rise = sSCL & ~dSCL; fall = ~sSCL & dSCL.
- The tx buffer is 8 bits plus a tx_full flag. tx_valid sets tx_full; loading the buffer into the shift register clears it. If tx_valid arrives while tx_full is set, the new byte overwrites the old.
- bit_cnt is 3 bits and counts down from 7.
- States:
  - IDLE: both oen = 1. On START go to ADDR.
  - ADDR: shift in sSDA on each rise. On the 8th rise, compare shift[7:1] with slv_addr and latch rw = bit 0. On the next fall:
    - Match: sda_oen = 0 (ACK), addr_match = 1, go to ADDR_ACK. If rw = 1, pulse tx_req.
    - No match: go to IDLE and ignore the bus until the next START.
  - ADDR_ACK: on fall, set sda_oen = 1.
    - rw = 0: go to RX.
    - rw = 1 and tx_full: load the shift register, sda_oen = bit7, go to TX.
    - rw = 1 and not tx_full: scl_oen = 0, go to WAIT_TX.
  - RX: shift in on each rise. On the 8th rise, update rx_data and pulse rx_valid. On the next fall, sda_oen = rx_nack, go to RX_ACK.
  - RX_ACK: on fall, sda_oen = 1, go to RX.
  - TX: on each fall, drive the next bit (sda_oen = bit value). On the fall after bit 0, sda_oen = 1 and go to TX_ACK.
  - TX_ACK: on rise, sample sSDA.
    - 0 (master ACK): pulse tx_req.
    - 1 (master NACK): on the next fall go to IDLE and wait for STOP or repeated START.
    - After an ACK, on fall: behave exactly as ADDR_ACK with rw = 1.
  - WAIT_TX: hold scl_oen = 0. When tx_full, load the shift register, set sda_oen = bit7, go to TX_SETUP.
  - TX_SETUP: scl_oen = 1 for one cycle (data setup before SCL release), then go to TX.
- START in any state: go to ADDR, reset bit_cnt, addr_match = 0, release both oen.
- STOP in any state: go to IDLE, pulse sto_det, addr_match = 0, release both oen.
- START and STOP are mutually exclusive per cycle; if detected on the same edge, STOP takes priority.
- The slave performs no arbitration checking.

## Timing
- Reset values:
  - scl_oen = 1, sda_oen = 1.
  - rx_data = 8'h00, rx_valid = 0, tx_req = 0.
  - addr_match = 0, rw = 0, busy = 0, sto_det = 0, tx_full = 0.
  - state = IDLE.
- Reset asserted mid-transfer releases both lines immediately (asynchronous).
- Line-to-detection latency: 2 clk for synchronization, plus 1 for the edge register.
- All outputs are registered.
  - rx_valid asserts 1 clk after the 8th rise detection.
  - sda_oen changes 1 clk after fall detection.
- Stretch release: tx_valid at cycle n → tx_full at n+1 → shift load and sda_oen at n+2 → scl_oen = 1 at n+3.
- busy updates 1 clk after START/STOP detection.

## Test plan
- Write to matching address: slv_addr = 7'h50, master sends START, 0xA0, 0x3C, STOP.
  - Required: ACK on both bytes, rx_data = 8'h3C, one rx_valid pulse, addr_match falls with the sto_det pulse.
- Non-matching address: master sends 0xA2.
  - Required: SDA never driven, state returns to IDLE, rx_valid never pulses.
- Read with data preloaded: tx_valid carries 0x96 before the address, master sends 0xA1.
  - Required: SDA bits are 1,0,0,1,0,1,1,0; tx_req pulses at the address ACK and again after the master ACK; master NACK → IDLE.
- Clock stretch: read with no tx data ready, tx_valid arrives 50 clk late.
  - Required: scl_oen = 0 throughout the wait; scl_oen = 1 exactly 3 clk after tx_valid; MSB is valid before SCL rises.
- Repeated START plus rx_nack: write 0xA0, 0x11 with rx_nack = 1, then repeated START 0xA1.
  - Required: SDA high at the data ACK slot; FSM re-enters ADDR; rw = 1.
- Reset or ena low mid-byte: required sda_oen = 1, scl_oen = 1, state IDLE, addr_match = 0.
